// File: rtl/hazard_unit_mc_if.sv
// Bundle of hazard-unit signals between the pipeline (master) and hazard_unit_mc (slave).
// The slave modport senses pipeline state and drives the stall/flush/freeze controls.
interface hazard_unit_mc_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  id_ex_mem_read;
  logic [REG_ADDR_W-1:0] id_ex_rd;
  logic [REG_ADDR_W-1:0] if_id_rs1;
  logic [REG_ADDR_W-1:0] if_id_rs2;
  logic                  if_id_rs1_used;
  logic                  if_id_rs2_used;
  logic                  ex_branch_taken;
  logic                  mem_req_valid;
  logic                  dmem_ready;
  logic                  pc_write;
  logic                  if_id_write;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  pipe_freeze;
  logic                  mem_timeout;
  logic [31:0]           perf_lu_cycles;
  logic [31:0]           perf_mem_cycles;

  modport master (
    output id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2, if_id_rs1_used, if_id_rs2_used,
           ex_branch_taken, mem_req_valid, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, mem_timeout,
           perf_lu_cycles, perf_mem_cycles
  );

  modport slave (
    input  id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2, if_id_rs1_used, if_id_rs2_used,
           ex_branch_taken, mem_req_valid, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, mem_timeout,
           perf_lu_cycles, perf_mem_cycles
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage RV32I core: multi-cycle load-use stall, branch flush, dmem freeze + watchdog.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_unit_mc #(
  parameter int REG_ADDR_W      = 5,
  parameter int LOAD_USE_STALLS = 1,
  parameter int MEM_TIMEOUT     = 256
) (
  input logic              clk,
  input logic              rst,
  hazard_unit_mc_if.slave  hz_if
);

  typedef enum logic {IDLE, LU_STALL} state_t;

  localparam logic [2:0]  LU_INIT = 3'(LOAD_USE_STALLS - 1);
  localparam logic [15:0] WD_MAX  = 16'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] wd_q;
  logic        tmo_q;
  logic        hz, frz, flush, lu_stall;

  assign hz = hz_if.id_ex_mem_read && (hz_if.id_ex_rd != '0) &&
              ((hz_if.if_id_rs1_used && (hz_if.id_ex_rd == hz_if.if_id_rs1)) ||
               (hz_if.if_id_rs2_used && (hz_if.id_ex_rd == hz_if.if_id_rs2)));
  assign frz      = hz_if.mem_req_valid && !hz_if.dmem_ready;
  assign flush    = hz_if.ex_branch_taken;
  // Once in LU_STALL the bubble continues even if the hazard inputs change.
  assign lu_stall = !frz && !flush && ((state_q == LU_STALL) || hz);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!frz) begin
      if (flush) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (state_q == LU_STALL) begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = IDLE;
      end else if (hz && (LOAD_USE_STALLS > 1)) begin
        state_d = LU_STALL;
        cnt_d   = LU_INIT;
      end
    end
  end

  always_comb begin
    hz_if.pc_write    = 1'b1;
    hz_if.if_id_write = 1'b1;
    hz_if.if_id_flush = 1'b0;
    hz_if.id_ex_flush = 1'b0;
    hz_if.pipe_freeze = 1'b0;
    if (frz) begin
      hz_if.pipe_freeze = 1'b1;
      hz_if.pc_write    = 1'b0;
      hz_if.if_id_write = 1'b0;
    end else if (flush) begin
      hz_if.if_id_flush = 1'b1;
      hz_if.id_ex_flush = 1'b1;
    end else if (lu_stall) begin
      hz_if.pc_write    = 1'b0;
      hz_if.if_id_write = 1'b0;
      hz_if.id_ex_flush = 1'b1;
    end
  end

  // Watchdog saturates at MEM_TIMEOUT so a very long freeze cannot wrap it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else if (frz) begin
      if (wd_q != WD_MAX) wd_q <= wd_q + 16'd1;
      if (wd_q >= WD_MAX - 16'd1) tmo_q <= 1'b1;
    end else begin
      wd_q <= '0;
    end
  end

  // The error shows in the same cycle the count reaches the limit, then sticks.
  assign hz_if.mem_timeout = tmo_q || (frz && (wd_q >= WD_MAX - 16'd1));

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_q, perf_mem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lu_q  <= '0;
      perf_mem_q <= '0;
    end else begin
      if (lu_stall && (perf_lu_q != 32'hFFFF_FFFF))  perf_lu_q  <= perf_lu_q + 32'd1;
      if (frz && (perf_mem_q != 32'hFFFF_FFFF))      perf_mem_q <= perf_mem_q + 32'd1;
    end
  end

  assign hz_if.perf_lu_cycles  = perf_lu_q;
  assign hz_if.perf_mem_cycles = perf_mem_q;
`else
  assign hz_if.perf_lu_cycles  = '0;
  assign hz_if.perf_mem_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Randomised bench for hazard_unit_mc: two configurations (1 stall / 3 stalls with short timeout)
// driven in lockstep and compared against a per-configuration behavioural model.
module tb_hazard_unit_mc;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  hazard_unit_mc_if #(.REG_ADDR_W(5)) if_a ();
  hazard_unit_mc_if #(.REG_ADDR_W(5)) if_b ();

  hazard_unit_mc #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1), .MEM_TIMEOUT(256)) u_dut_a (
    .clk(clk), .rst(rst), .hz_if(if_a.slave)
  );
  hazard_unit_mc #(.REG_ADDR_W(5), .LOAD_USE_STALLS(3), .MEM_TIMEOUT(4)) u_dut_b (
    .clk(clk), .rst(rst), .hz_if(if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: remaining bubbles, consecutive frozen cycles, sticky error, perf counts.
  int     cfg_stalls [2] = '{1, 3};
  int     cfg_tmo    [2] = '{256, 4};
  int     m_rem      [2];
  int     m_frz_run  [2];
  bit     m_tmo      [2];
  longint m_lu       [2];
  longint m_mem      [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = 0; m_frz_run[k] = 0; m_tmo[k] = 0; m_lu[k] = 0; m_mem[k] = 0;
    end
  endtask

  task automatic step(input bit r, input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input bit u1, input bit u2, input bit br,
                      input bit mv, input bit rdy);
    bit frz, hz, stall;
    bit e_pc, e_ifw, e_iff, e_idf, e_pf, e_mt;
    logic [31:0] e_plu, e_pmem;
    @(posedge clk);
    #1;
    rst = r;
    if_a.id_ex_mem_read = mr;  if_b.id_ex_mem_read = mr;
    if_a.id_ex_rd = rd;        if_b.id_ex_rd = rd;
    if_a.if_id_rs1 = rs1;      if_b.if_id_rs1 = rs1;
    if_a.if_id_rs2 = rs2;      if_b.if_id_rs2 = rs2;
    if_a.if_id_rs1_used = u1;  if_b.if_id_rs1_used = u1;
    if_a.if_id_rs2_used = u2;  if_b.if_id_rs2_used = u2;
    if_a.ex_branch_taken = br; if_b.ex_branch_taken = br;
    if_a.mem_req_valid = mv;   if_b.mem_req_valid = mv;
    if_a.dmem_ready = rdy;     if_b.dmem_ready = rdy;
    if (r) model_reset();
    #4;
    frz = mv && !rdy;
    hz  = mr && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
    for (int k = 0; k < 2; k++) begin
      stall = 0;
      e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_pf = 0;
      if (frz) begin
        e_pf = 1; e_pc = 0; e_ifw = 0;
      end else if (br) begin
        e_iff = 1; e_idf = 1;
      end else if (m_rem[k] > 0 || hz) begin
        stall = 1; e_pc = 0; e_ifw = 0; e_idf = 1;
      end
      e_mt = m_tmo[k] || (frz && (m_frz_run[k] + 1 >= cfg_tmo[k]));
`ifdef HAZARD_PERF_CNT_EN
      e_plu  = 32'(m_lu[k]);
      e_pmem = 32'(m_mem[k]);
`else
      e_plu  = 32'd0;
      e_pmem = 32'd0;
`endif
      chk($sformatf("pc_write[%0d]", k),        32'(k == 0 ? if_a.pc_write : if_b.pc_write), 32'(e_pc));
      chk($sformatf("if_id_write[%0d]", k),     32'(k == 0 ? if_a.if_id_write : if_b.if_id_write), 32'(e_ifw));
      chk($sformatf("if_id_flush[%0d]", k),     32'(k == 0 ? if_a.if_id_flush : if_b.if_id_flush), 32'(e_iff));
      chk($sformatf("id_ex_flush[%0d]", k),     32'(k == 0 ? if_a.id_ex_flush : if_b.id_ex_flush), 32'(e_idf));
      chk($sformatf("pipe_freeze[%0d]", k),     32'(k == 0 ? if_a.pipe_freeze : if_b.pipe_freeze), 32'(e_pf));
      chk($sformatf("mem_timeout[%0d]", k),     32'(k == 0 ? if_a.mem_timeout : if_b.mem_timeout), 32'(e_mt));
      chk($sformatf("perf_lu_cycles[%0d]", k),  k == 0 ? if_a.perf_lu_cycles : if_b.perf_lu_cycles, e_plu);
      chk($sformatf("perf_mem_cycles[%0d]", k), k == 0 ? if_a.perf_mem_cycles : if_b.perf_mem_cycles, e_pmem);
      if (!r) begin
        if (frz) begin
          m_frz_run[k]++;
          if (m_frz_run[k] >= cfg_tmo[k]) m_tmo[k] = 1;
          if (m_mem[k] < 64'hFFFF_FFFF) m_mem[k]++;
        end else begin
          m_frz_run[k] = 0;
          if (br) m_rem[k] = 0;
          else if (stall) begin
            if (m_rem[k] == 0) m_rem[k] = cfg_stalls[k] - 1;
            else m_rem[k]--;
            if (m_lu[k] < 64'hFFFF_FFFF) m_lu[k]++;
          end
        end
      end
    end
  endtask

  function automatic logic [4:0] pick_reg();
    logic [4:0] regs [4] = '{5'd0, 5'd5, 5'd6, 5'd7};
    return regs[$urandom_range(0, 3)];
  endfunction

  initial begin
    int run;
    n_cmp = 0;
    n_err = 0;
    run   = 0;
    model_reset();
    // reset state, then idle traffic
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 5, 5, 0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // load x5 with rs1 use: one bubble / three bubbles
    step(0, 1, 5, 5, 0, 1, 0, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // rs2 match but unused, then rd = x0
    repeat (3) step(0, 1, 5, 0, 5, 0, 0, 0, 0, 1);
    repeat (3) step(0, 1, 0, 0, 0, 1, 1, 0, 0, 1);
    // freeze during the 2nd stall cycle
    step(0, 1, 5, 5, 0, 1, 0, 0, 1, 1);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    // hazard together with taken branch
    step(0, 1, 5, 5, 0, 1, 0, 1, 0, 1);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // branch held while frozen, applied when dmem_ready rises
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    // 6-cycle freeze trips the short watchdog; reset clears it
    repeat (6) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // reset mid-stall
    step(0, 1, 6, 6, 6, 1, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // random traffic with occasional long freezes, branches and resets
    for (int i = 0; i < 3000; i++) begin
      bit mv, rdy;
      if (run > 0) begin
        mv = 1; rdy = 0; run--;
      end else if ($urandom_range(0, 15) == 0) begin
        run = $urandom_range(1, 7);
        mv = 1; rdy = 0;
      end else begin
        mv  = 1'($urandom_range(0, 1));
        rdy = ($urandom_range(0, 3) != 0);
      end
      step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), pick_reg(), pick_reg(), pick_reg(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), mv, rdy);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
